// File: rtl/message_streamer_pkg.sv
// message_streamer_pkg
//   Shared types and constants for the message streamer slice:
//   - state_t      : sequencer states (idle, sending, inter-char gap, done)
//   - char_t/len_t : character and length types for the default 8-bit/16-entry build
//   - DEFAULT_MSG  : "Hello World!" power-on message; default_char() returns
//                    one character of it, zero beyond the end of the text.
package message_streamer_pkg;

  localparam int DEF_CHAR_W = 8;
  localparam int DEF_DEPTH  = 16;

  typedef logic [DEF_CHAR_W-1:0]              char_t;
  typedef logic [$clog2(DEF_DEPTH+1)-1:0]     len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam int                  MSG_LEN     = 12;
  localparam logic [MSG_LEN*8-1:0] DEFAULT_MSG = "Hello World!";

  // The first character sits in the most significant byte of the literal.
  function automatic char_t default_char(input int idx);
    char_t c;
    c = '0;
    if (idx >= 0 && idx < MSG_LEN) begin
      c = DEFAULT_MSG[(MSG_LEN-1-idx)*8 +: 8];
    end
    return c;
  endfunction

endpackage

// File: rtl/message_streamer_mem.sv
// message_streamer_mem
//   Message storage with a registered read port.
//   Default build: constant ROM holding the default message, zero padded.
//   MESSAGE_STREAMER_LOAD_EN defined: 1W1R RAM preloaded with the default
//   message; writes with _wr_addr >= DEPTH are dropped.
// Ports
//   _clock    in   1       clock
//   _reset    in   1       synchronous active-high; clears only _rd_data
//   _rd_en    in   1       load _rd_data from the addressed entry
//   _rd_addr  in   ADDR_W  read address
//   _rd_data  out  CHAR_W  registered read data (holds when _rd_en=0)
//   _wr_en/_wr_addr/_wr_data  write port (LOAD_EN builds only)
module message_streamer_mem
  import message_streamer_pkg::*;
#(
  parameter int CHAR_W = 8,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = $clog2(DEPTH+1),
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              _clock,
  input  logic              _reset,
  input  logic              _rd_en,
  input  logic [ADDR_W-1:0] _rd_addr,
`ifdef MESSAGE_STREAMER_LOAD_EN
  input  logic              _wr_en,
  input  logic [LEN_W-1:0]  _wr_addr,
  input  logic [CHAR_W-1:0] _wr_data,
`endif
  output logic [CHAR_W-1:0] _rd_data
);

  logic [CHAR_W-1:0] rd_data_reg;

`ifdef MESSAGE_STREAMER_LOAD_EN
  typedef logic [CHAR_W-1:0] image_t [DEPTH];

  function automatic image_t default_image();
    image_t img;
    for (int i = 0; i < DEPTH; i++) begin
      img[i] = CHAR_W'(default_char(i));
    end
    return img;
  endfunction

  // Power-on contents are the default message; reset leaves them alone.
  image_t mem_reg = default_image();

  always_ff @(posedge _clock) begin
    if (_wr_en && (_wr_addr < LEN_W'(DEPTH))) begin
      mem_reg[_wr_addr[ADDR_W-1:0]] <= _wr_data;
    end
  end

  // Read-before-write: a same-cycle write to the read entry returns old data.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      rd_data_reg <= '0;
    end else if (_rd_en) begin
      rd_data_reg <= mem_reg[_rd_addr];
    end
  end
`else
  logic [CHAR_W-1:0] rom_table [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    assign rom_table[gi] = CHAR_W'(default_char(gi));
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      rd_data_reg <= '0;
    end else if (_rd_en) begin
      rd_data_reg <= rom_table[_rd_addr];
    end
  end
`endif

  assign _rd_data = rd_data_reg;

endmodule

// File: rtl/message_streamer.sv
// message_streamer
//   Streams a stored message one character per valid/ready transfer.
//   Start/done control, programmable length (clamped to DEPTH), loop mode and
//   an optional GAP-cycle idle after every accepted character.
//   Optional macro MESSAGE_STREAMER_LOAD_EN adds a memory write port.
// Ports
//   _clock  in  1       clock (posedge)
//   _reset  in  1       synchronous active-high reset
//   _enable in  1       gates launching new chars and gap counting
//   _start  in  1       begin a message (accepted in idle only)
//   _loop   in  1       restart at index 0 after the last char
//   _len    in  LEN_W   chars to send, sampled with an accepted _start
//   _letter out CHAR_W  current character (registered)
//   _valid  out 1       _letter holds a character
//   _ready  in  1       sink accepts (transfer = _valid & _ready)
//   _busy   out 1       message in progress (through the done cycle)
//   _done   out 1       one-cycle pulse at the end of a non-looping pass
//   _index  out LEN_W   index of the char on _letter
//   _wr_en/_wr_addr/_wr_data  memory write port (LOAD_EN builds only)
module message_streamer
  import message_streamer_pkg::*;
#(
  parameter int CHAR_W = 8,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = $clog2(DEPTH+1),
  parameter int GAP    = 0
) (
  input  logic              _clock,
  input  logic              _reset,
  input  logic              _enable,
  input  logic              _start,
  input  logic              _loop,
  input  logic [LEN_W-1:0]  _len,
  output logic [CHAR_W-1:0] _letter,
  output logic              _valid,
  input  logic              _ready,
  output logic              _busy,
  output logic              _done,
`ifdef MESSAGE_STREAMER_LOAD_EN
  input  logic              _wr_en,
  input  logic [LEN_W-1:0]  _wr_addr,
  input  logic [CHAR_W-1:0] _wr_data,
`endif
  output logic [LEN_W-1:0]  _index
);

  localparam int                ADDR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                GAP_W    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;
  localparam logic [LEN_W-1:0]  DEPTH_L  = LEN_W'(DEPTH);

  state_t            state_reg,   state_next;
  logic              valid_reg,   valid_next;
  logic [LEN_W-1:0]  index_reg,   index_next;   // char currently on _letter
  logic [LEN_W-1:0]  fetch_reg,   fetch_next;   // next entry to read
  logic [LEN_W-1:0]  len_q_reg,   len_q_next;
  logic [GAP_W-1:0]  gap_cnt_reg, gap_cnt_next;

  logic              rd_en;
  logic [LEN_W-1:0]  len_clamped;
  logic [LEN_W-1:0]  last_idx;
  logic [LEN_W-1:0]  fetch_after;
  logic              transfer;
  logic              at_last;

  assign len_clamped = (_len > DEPTH_L) ? DEPTH_L : _len;
  assign last_idx    = len_q_reg - LEN_W'(1);
  assign transfer    = valid_reg & _ready;
  assign at_last     = (index_reg == last_idx);
  // The fetch pointer always wraps; whether the wrapped char is ever shown
  // is decided by _loop when the last char is accepted.
  assign fetch_after = (fetch_reg == last_idx) ? '0 : fetch_reg + LEN_W'(1);

  always_comb begin
    state_next   = state_reg;
    valid_next   = valid_reg;
    index_next   = index_reg;
    fetch_next   = fetch_reg;
    len_q_next   = len_q_reg;
    gap_cnt_next = gap_cnt_reg;
    rd_en        = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (_start) begin
          len_q_next = len_clamped;
          index_next = '0;
          fetch_next = '0;
          state_next = (_len == '0) ? ST_DONE : ST_SEND;
        end
      end

      ST_SEND: begin
        if (transfer) begin
          if (at_last && !_loop) begin
            valid_next = 1'b0;
            state_next = ST_DONE;
          end else if (GAP > 0) begin
            valid_next   = 1'b0;
            gap_cnt_next = '0;
            state_next   = ST_GAP;
          end else if (_enable) begin
            rd_en      = 1'b1;
            valid_next = 1'b1;
            index_next = fetch_reg;
            fetch_next = fetch_after;
          end else begin
            valid_next = 1'b0;
          end
        end else if (!valid_reg && _enable) begin
          rd_en      = 1'b1;
          valid_next = 1'b1;
          index_next = fetch_reg;
          fetch_next = fetch_after;
        end
      end

      ST_GAP: begin
        // The final gap cycle launches the fetch itself so that exactly GAP
        // cycles of _valid=0 separate consecutive characters.
        if (_enable) begin
          if (gap_cnt_reg == GAP_LAST) begin
            rd_en      = 1'b1;
            valid_next = 1'b1;
            index_next = fetch_reg;
            fetch_next = fetch_after;
            state_next = ST_SEND;
          end else begin
            gap_cnt_next = gap_cnt_reg + GAP_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_reg   <= ST_IDLE;
      valid_reg   <= 1'b0;
      index_reg   <= '0;
      fetch_reg   <= '0;
      len_q_reg   <= '0;
      gap_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      valid_reg   <= valid_next;
      index_reg   <= index_next;
      fetch_reg   <= fetch_next;
      len_q_reg   <= len_q_next;
      gap_cnt_reg <= gap_cnt_next;
    end
  end

  message_streamer_mem #(
    .CHAR_W (CHAR_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    ._clock   (_clock),
    ._reset   (_reset),
    ._rd_en   (rd_en),
    ._rd_addr (fetch_reg[ADDR_W-1:0]),
`ifdef MESSAGE_STREAMER_LOAD_EN
    ._wr_en   (_wr_en),
    ._wr_addr (_wr_addr),
    ._wr_data (_wr_data),
`endif
    ._rd_data (_letter)
  );

  assign _valid = valid_reg;
  assign _index = index_reg;
  assign _busy  = (state_reg != ST_IDLE);
  assign _done  = (state_reg == ST_DONE);

endmodule
